// File: rtl/gcd_pkg.sv
// Shared GCD types and helpers.
// Engine state encoding for the Stein GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    SUB,
    DONE
  } gcd_eng_state_t;

  function automatic int unsigned min_u(
    input int unsigned x,
    input int unsigned y
  );
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/gcd_tzc.sv
// Combinational trailing-zero counter.
// cnt is 0 when value is zero; all_zero flags that case.
module gcd_tzc #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    cnt,
  output logic             all_zero
);

  // Scan MSB to LSB so the lowest set bit wins.
  always_comb begin
    cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (value[i]) cnt = CW'(i);
    end
  end

  assign all_zero = (value == '0);

endmodule

// File: rtl/gcd_stein_engine.sv
// Binary (Stein) GCD engine with valid/ready streaming ports.
// One subtract-and-normalise step per SUB cycle.
module gcd_stein_engine
  import gcd_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int CNTW = $clog2(2 * XLEN + 2)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            abort_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] gcd_o,
  output logic            zero_o,
  output logic [CNTW-1:0] cycles_o
);

  localparam int KW = $clog2(XLEN);

  gcd_eng_state_t state, state_n;

  logic [XLEN-1:0] a_q, a_n;
  logic [XLEN-1:0] b_q, b_n;
  logic [KW-1:0]   k_q, k_n;
  logic [CNTW-1:0] cnt_q, cnt_n, cnt_inc;
  logic [XLEN-1:0] gcd_n;
  logic            zero_n;
  logic [CNTW-1:0] cyc_n;

  logic            a_gt;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] tza_in;
  logic [KW-1:0]   tz_a, tz_b;
  logic            za, zb;

  // One magnitude subtractor; in SUB the A-side counter sees it.
  assign a_gt   = a_q > b_q;
  assign diff   = a_gt ? a_q - b_q : b_q - a_q;
  assign tza_in = (state == SUB) ? diff : a_q;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  gcd_tzc #(.WIDTH(XLEN)) u_tz_a (
    .value    (tza_in),
    .cnt      (tz_a),
    .all_zero (za)
  );

  gcd_tzc #(.WIDTH(XLEN)) u_tz_b (
    .value    (b_q),
    .cnt      (tz_b),
    .all_zero (zb)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    k_n     = k_q;
    cnt_n   = cnt_q;
    gcd_n   = gcd_o;
    zero_n  = zero_o;
    cyc_n   = cycles_o;
    if (abort_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_n     = a_i;
            b_n     = b_i;
            cnt_n   = '0;
            state_n = NORM;
          end
        end
        NORM: begin
          if (za || zb) begin
            gcd_n   = a_q | b_q;
            zero_n  = za & zb;
            cyc_n   = '0;
            state_n = DONE;
          end else begin
            k_n     = KW'(min_u(32'(tz_a), 32'(tz_b)));
            a_n     = a_q >> tz_a;
            b_n     = b_q >> tz_b;
            state_n = SUB;
          end
        end
        SUB: begin
          cnt_n = cnt_inc;
          // A zero difference means the odd parts have met.
          if (za) begin
            gcd_n   = a_q << k_q;
            zero_n  = 1'b0;
            cyc_n   = cnt_inc;
            state_n = DONE;
          end else if (a_gt) begin
            a_n = diff >> tz_a;
          end else begin
            b_n = diff >> tz_a;
          end
        end
        DONE: begin
          if (out_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      gcd_o    <= '0;
      zero_o   <= 1'b0;
      cycles_o <= '0;
    end else begin
      a_q      <= a_n;
      b_q      <= b_n;
      k_q      <= k_n;
      cnt_q    <= cnt_n;
      gcd_o    <= gcd_n;
      zero_o   <= zero_n;
      cycles_o <= cyc_n;
    end
  end

endmodule

// File: tb/tb_gcd_stein_engine.sv
// Directed bench for gcd_stein_engine.
// Table of hand-computed vectors plus backpressure/abort/reset sequences.
module tb_gcd_stein_engine;

  localparam int XLEN = 32;
  localparam int CNTW = $clog2(2 * XLEN + 2);

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            abort_i = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] gcd_o;
  logic            zero_o;
  logic [CNTW-1:0] cycles_o;

  int n_vec = 0;
  int n_err = 0;

  gcd_stein_engine #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .abort_i   (abort_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_o     (gcd_o),
    .zero_o    (zero_o),
    .cycles_o  (cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] g;
    logic        z;
    int          cyc;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    check("accept_ready", in_ready, 1);
    a_i      = a;
    b_i      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_deliver_valid", out_valid, 0);
    check("post_deliver_ready", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start(v.a, v.b);
    wait_out(lat);
    if (!out_valid) return;
    check($sformatf("gcd(%0h,%0h)", v.a, v.b), gcd_o, v.g);
    check($sformatf("zero(%0h,%0h)", v.a, v.b), zero_o, v.z);
    check($sformatf("cycles(%0h,%0h)", v.a, v.b), cycles_o, v.cyc);
    check($sformatf("latency(%0h,%0h)", v.a, v.b), lat, v.lat);
    deliver();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   lat;
    vec_t v;

    vecs[0]  = '{32'd48, 32'd18, 32'd6, 1'b0, 2, 4};
    vecs[1]  = '{32'd0, 32'd35, 32'd35, 1'b0, 0, 2};
    vecs[2]  = '{32'd0, 32'd0, 32'd0, 1'b1, 0, 2};
    vecs[3]  = '{32'd35, 32'd0, 32'd35, 1'b0, 0, 2};
    vecs[4]  = '{32'h8000_0000, 32'h0010_0000, 32'h0010_0000, 1'b0, 1, 3};
    vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 32, 34};
    vecs[6]  = '{32'd12, 32'd8, 32'd4, 1'b0, 2, 4};
    vecs[7]  = '{32'd21, 32'd14, 32'd7, 1'b0, 2, 4};
    vecs[8]  = '{32'd7, 32'd7, 32'd7, 1'b0, 1, 3};
    vecs[9]  = '{32'd1, 32'd1, 32'd1, 1'b0, 1, 3};
    vecs[10] = '{32'd64, 32'd48, 32'd16, 1'b0, 2, 4};
    vecs[11] = '{32'd270, 32'd192, 32'd6, 1'b0, 4, 6};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_gcd", gcd_o, 0);
    check("rst_zero", zero_o, 0);
    check("rst_cycles", cycles_o, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: result held 5 cycles; new pair offered at handshake.
    start(32'd48, 32'd18);
    wait_out(lat);
    check("bp_latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_gcd", gcd_o, 6);
      check("bp_cycles", cycles_o, 2);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    a_i      = 32'd9;
    b_i      = 32'd6;
    in_valid = 1'b1;
    deliver();
    in_valid = 1'b0;

    // Abort on the third SUB cycle of a long pair.
    start(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_valid", out_valid, 0);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check("abort_idle_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_still_quiet", out_valid, 0);

    // Abort beats an input handshake in the same cycle.
    a_i      = 32'd5;
    b_i      = 32'd5;
    in_valid = 1'b1;
    abort_i  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort_i  = 1'b0;
    check("abort_blocks_accept", in_ready, 1);

    v = '{32'd12, 32'd8, 32'd4, 1'b0, 2, 4};
    run_vec(v);

    // Asynchronous reset between clock edges mid-SUB.
    start(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_gcd", gcd_o, 0);
    check("async_rst_cycles", cycles_o, 0);
    check("async_rst_zero", zero_o, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);

    v = '{32'd21, 32'd14, 32'd7, 1'b0, 2, 4};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
